// File: rtl/axil_sel_seq.sv
// axil_sel_seq: AXI-Lite sequencer that forwards one upstream transaction at a
// time to the user-project mux and applies user-project select changes only
// between transactions.
// Optional feature macro: AXIL_SEL_TIMEOUT_EN (downstream timeout with
// self-completion and a sticky error flag). Without it, every state waits
// indefinitely and err_sticky is tied low.
module axil_sel_seq #(
   parameter int pDATA_WIDTH = 32,
   parameter int pTIMEOUT    = 255
) (
   input  logic                   axi_clk,
   input  logic                   axi_reset_n,
   // upstream AXI-Lite slave side
   input  logic                   s_awvalid,
   output logic                   s_awready,
   input  logic [14:0]            s_awaddr,
   input  logic                   s_wvalid,
   output logic                   s_wready,
   input  logic [pDATA_WIDTH-1:0] s_wdata,
   input  logic [3:0]             s_wstrb,
   input  logic                   s_arvalid,
   output logic                   s_arready,
   input  logic [14:0]            s_araddr,
   output logic                   s_rvalid,
   input  logic                   s_rready,
   output logic [pDATA_WIDTH-1:0] s_rdata,
   // downstream AXI-Lite master side, towards the user-project mux
   output logic                   m_awvalid,
   input  logic                   m_awready,
   output logic [14:0]            m_awaddr,
   output logic                   m_wvalid,
   input  logic                   m_wready,
   output logic [pDATA_WIDTH-1:0] m_wdata,
   output logic [3:0]             m_wstrb,
   output logic                   m_arvalid,
   input  logic                   m_arready,
   output logic [14:0]            m_araddr,
   input  logic                   m_rvalid,
   output logic                   m_rready,
   input  logic [pDATA_WIDTH-1:0] m_rdata,
   // user-project select
   input  logic [4:0]             sel_req,
   input  logic                   sel_req_valid,
   output logic [4:0]             user_prj_sel,
   output logic                   sel_ack,
   output logic                   err_sticky,
   input  logic                   err_clr
);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_RD_A   = 3'd2,
      ST_RD_D   = 3'd3,
      ST_SWITCH = 3'd4
   } state_t;

   state_t      r_state;
   logic        r_aw_done;
   logic        r_w_done;
   logic        r_rr_wr;       // 1: write has priority at the next tie
   logic        r_pend_valid;
   logic [4:0]  r_pend_sel;
   logic [4:0]  r_user_sel;
   logic        r_sel_ack;

   logic        w_wr_elig;
   logic        w_rd_elig;
   logic        w_aw_fire;
   logic        w_w_fire;
   logic        w_ar_fire;
   logic        w_r_fire;
   logic        w_tmo;
   logic        w_unused;

   assign w_wr_elig = s_awvalid & s_wvalid;
   assign w_rd_elig = s_arvalid;
   // upstream-side handshakes; in normal operation they coincide with the
   // downstream handshakes, and on timeout they are the self-completion
   assign w_aw_fire = s_awvalid & s_awready;
   assign w_w_fire  = s_wvalid  & s_wready;
   assign w_ar_fire = s_arvalid & s_arready;
   assign w_r_fire  = s_rvalid  & s_rready;

   // addresses: only the low 12 bits select a register in the user project
   assign m_awaddr = {3'b000, s_awaddr[11:0]};
   assign m_araddr = {3'b000, s_araddr[11:0]};
   assign m_wdata  = s_wdata;
   assign m_wstrb  = s_wstrb;

   assign user_prj_sel = r_user_sel;
   assign sel_ack      = r_sel_ack;

`ifdef AXIL_SEL_TIMEOUT_EN
   localparam logic [9:0] lpTMO = 10'(pTIMEOUT);

   logic [9:0]  r_tmo_cnt;
   logic        r_err;

   // the counter saturates at lpTMO, so an expired read data phase keeps
   // presenting the error response until the upstream accepts it
   assign w_tmo      = (r_tmo_cnt == lpTMO) &&
                       ((r_state == ST_WR) || (r_state == ST_RD_A) || (r_state == ST_RD_D));
   assign err_sticky = r_err;
   assign w_unused   = &{1'b0, s_awaddr[14:12], s_araddr[14:12]};
`else
   assign w_tmo      = 1'b0;
   assign err_sticky = 1'b0;
   assign w_unused   = &{1'b0, s_awaddr[14:12], s_araddr[14:12], err_clr};
`endif

   // channel gating: forward only the channels of the transaction in flight
   always_comb begin
      s_awready = 1'b0;
      s_wready  = 1'b0;
      s_arready = 1'b0;
      s_rvalid  = 1'b0;
      s_rdata   = {pDATA_WIDTH{1'b0}};
      m_awvalid = 1'b0;
      m_wvalid  = 1'b0;
      m_arvalid = 1'b0;
      m_rready  = 1'b0;
      case (r_state)
         ST_WR: begin
            if (w_tmo) begin
               s_awready = ~r_aw_done;
               s_wready  = ~r_w_done;
            end else begin
               m_awvalid = s_awvalid & ~r_aw_done;
               s_awready = m_awready & ~r_aw_done;
               m_wvalid  = s_wvalid  & ~r_w_done;
               s_wready  = m_wready  & ~r_w_done;
            end
         end
         ST_RD_A: begin
            if (w_tmo) begin
               s_arready = 1'b1;
            end else begin
               m_arvalid = s_arvalid;
               s_arready = m_arready;
            end
         end
         ST_RD_D: begin
            if (w_tmo) begin
               s_rvalid = 1'b1;
               s_rdata  = {pDATA_WIDTH{1'b1}};
            end else begin
               s_rvalid = m_rvalid;
               m_rready = s_rready;
               s_rdata  = m_rdata;
            end
         end
         default: begin
            s_awready = 1'b0;
         end
      endcase
   end

   // sequencer FSM with pending select, round-robin pointer and timeout state
   always_ff @(posedge axi_clk or negedge axi_reset_n) begin
      if (!axi_reset_n) begin
         r_state      <= ST_IDLE;
         r_aw_done    <= 1'b0;
         r_w_done     <= 1'b0;
         r_rr_wr      <= 1'b1;
         r_pend_valid <= 1'b0;
         r_pend_sel   <= 5'b00000;
         r_user_sel   <= 5'b00000;
         r_sel_ack    <= 1'b0;
`ifdef AXIL_SEL_TIMEOUT_EN
         r_tmo_cnt    <= 10'd0;
         r_err        <= 1'b0;
`endif
      end else begin
         r_sel_ack <= 1'b0;
         if (sel_req_valid) begin
            r_pend_sel   <= sel_req;
            r_pend_valid <= 1'b1;
         end
`ifdef AXIL_SEL_TIMEOUT_EN
         if (w_tmo) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
         if ((r_state != ST_IDLE) && (r_state != ST_SWITCH) && (r_tmo_cnt != lpTMO)) begin
            r_tmo_cnt <= r_tmo_cnt + 10'd1;
         end
`endif
         case (r_state)
            ST_IDLE: begin
               if (r_pend_valid) begin
                  r_state <= ST_SWITCH;
               end else if (w_wr_elig && (r_rr_wr || !w_rd_elig)) begin
                  r_state   <= ST_WR;
                  r_rr_wr   <= 1'b0;
                  r_aw_done <= 1'b0;
                  r_w_done  <= 1'b0;
`ifdef AXIL_SEL_TIMEOUT_EN
                  r_tmo_cnt <= 10'd0;
`endif
               end else if (w_rd_elig) begin
                  r_state <= ST_RD_A;
                  r_rr_wr <= 1'b1;
`ifdef AXIL_SEL_TIMEOUT_EN
                  r_tmo_cnt <= 10'd0;
`endif
               end
            end
            ST_WR: begin
               r_aw_done <= r_aw_done | w_aw_fire;
               r_w_done  <= r_w_done  | w_w_fire;
               if (w_tmo || ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire))) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RD_A: begin
               if (w_ar_fire || w_tmo) begin
                  r_state <= ST_RD_D;
`ifdef AXIL_SEL_TIMEOUT_EN
                  // an expired address phase enters RD_D already expired so the
                  // upstream gets its error response without further waiting
                  if (!w_tmo) begin
                     r_tmo_cnt <= 10'd0;
                  end
`endif
               end
            end
            ST_RD_D: begin
               if (w_r_fire) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_SWITCH: begin
               r_user_sel <= r_pend_sel;
               r_sel_ack  <= 1'b1;
               // a strobe landing in this cycle stays pending for a later SWITCH
               if (!sel_req_valid) begin
                  r_pend_valid <= 1'b0;
               end
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axil_sel_seq.sv
// Self-checking bench for axil_sel_seq: scoreboard queues hold the expected
// downstream beats, upstream read data and select values.
module tb_axil_sel_seq;

   localparam int DW = 32;

   logic          axi_clk = 1'b0;
   logic          axi_reset_n = 1'b0;
   logic          s_awvalid = 1'b0, s_awready;
   logic [14:0]   s_awaddr = 15'd0;
   logic          s_wvalid = 1'b0, s_wready;
   logic [DW-1:0] s_wdata = 32'd0;
   logic [3:0]    s_wstrb = 4'd0;
   logic          s_arvalid = 1'b0, s_arready;
   logic [14:0]   s_araddr = 15'd0;
   logic          s_rvalid, s_rready = 1'b0;
   logic [DW-1:0] s_rdata;
   logic          m_awvalid, m_awready = 1'b0;
   logic [14:0]   m_awaddr;
   logic          m_wvalid, m_wready = 1'b0;
   logic [DW-1:0] m_wdata;
   logic [3:0]    m_wstrb;
   logic          m_arvalid, m_arready = 1'b0;
   logic [14:0]   m_araddr;
   logic          m_rvalid = 1'b0, m_rready;
   logic [DW-1:0] m_rdata = 32'd0;
   logic [4:0]    sel_req = 5'd0;
   logic          sel_req_valid = 1'b0;
   logic [4:0]    user_prj_sel;
   logic          sel_ack, err_sticky;
   logic          err_clr = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   logic [14:0]   q_addr[$];
   logic [35:0]   q_wdat[$];
   logic [31:0]   q_rdat[$];
   logic [4:0]    q_sel[$];
   logic          q_ord[$];   // 1 = write, 0 = read

   always #5 axi_clk = ~axi_clk;

   axil_sel_seq #(.pDATA_WIDTH(DW), .pTIMEOUT(16)) dut (
      .axi_clk(axi_clk), .axi_reset_n(axi_reset_n),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata),
      .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
      .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
      .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
      .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
      .sel_req(sel_req), .sel_req_valid(sel_req_valid), .user_prj_sel(user_prj_sel),
      .sel_ack(sel_ack), .err_sticky(err_sticky), .err_clr(err_clr)
   );

   task automatic step();
      @(posedge axi_clk);
      #1;
   endtask

   task automatic clear_inputs();
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0; s_rready = 1'b0;
      m_awready = 1'b0; m_wready = 1'b0; m_arready = 1'b0; m_rvalid = 1'b0;
      m_rdata = 32'd0; sel_req = 5'd0; sel_req_valid = 1'b0; err_clr = 1'b0;
   endtask

   task automatic apply_reset();
      axi_reset_n = 1'b0;
      clear_inputs();
      step();
      step();
      axi_reset_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      axi_reset_n = 1'b0;
      s_awvalid = 1'b1; s_wvalid = 1'b1; s_arvalid = 1'b1; s_rready = 1'b1;
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1;
      m_rdata = 32'hFFFFFFFF; sel_req = 5'h1F; sel_req_valid = 1'b1; err_clr = 1'b0;
      repeat (2) @(posedge axi_clk);
      #2;
      n_checks++;
      if ({s_awready, s_wready, s_arready, s_rvalid} !== 4'b0000) begin
         n_errors++; $display("FAIL reset_s_ready: got %b expected 0000", {s_awready, s_wready, s_arready, s_rvalid});
      end
      n_checks++;
      if ({m_awvalid, m_wvalid, m_arvalid} !== 3'b000) begin
         n_errors++; $display("FAIL reset_m_valid: got %b expected 000", {m_awvalid, m_wvalid, m_arvalid});
      end
      n_checks++;
      if (s_rdata !== 32'd0) begin
         n_errors++; $display("FAIL reset_rdata: got %h expected 00000000", s_rdata);
      end
      n_checks++;
      if (user_prj_sel !== 5'd0) begin
         n_errors++; $display("FAIL reset_sel: got %h expected 00", user_prj_sel);
      end
      n_checks++;
      if (sel_ack !== 1'b0) begin
         n_errors++; $display("FAIL reset_ack: got %b expected 0", sel_ack);
      end
      n_checks++;
      if (err_sticky !== 1'b0) begin
         n_errors++; $display("FAIL reset_err: got %b expected 0", err_sticky);
      end
      clear_inputs();
      step();
      axi_reset_n = 1'b1;
      step();
   endtask

   task automatic test_write();
      int aw_hs = 0;
      int w_hs = 0;
      int aw_wait = 0;
      logic [14:0] ea;
      logic [35:0] ew;
      q_addr.push_back(15'h00AB);
      q_wdat.push_back({4'hF, 32'h12345678});
      s_awvalid = 1'b1; s_awaddr = 15'h70AB;
      s_wvalid = 1'b1; s_wdata = 32'h12345678; s_wstrb = 4'hF;
      m_awready = 1'b0; m_wready = 1'b1;
      for (int c = 0; c < 20 && aw_hs == 0; c++) begin
         #2;
         if (m_awvalid && m_awready) begin
            aw_hs++;
            n_checks++;
            if (q_addr.size() == 0) begin
               n_errors++; $display("FAIL wr_awaddr: got %h expected nothing", m_awaddr);
            end else begin
               ea = q_addr.pop_front();
               if (m_awaddr !== ea) begin
                  n_errors++; $display("FAIL wr_awaddr: got %h expected %h", m_awaddr, ea);
               end
            end
         end else if (m_awvalid) begin
            aw_wait++;
         end
         if (m_wvalid && m_wready) begin
            w_hs++;
            n_checks++;
            if (q_wdat.size() == 0) begin
               n_errors++; $display("FAIL wr_wdata: got %h expected nothing", {m_wstrb, m_wdata});
            end else begin
               ew = q_wdat.pop_front();
               if ({m_wstrb, m_wdata} !== ew) begin
                  n_errors++; $display("FAIL wr_wdata: got %h expected %h", {m_wstrb, m_wdata}, ew);
               end
            end
         end
         step();
         if (aw_wait == 3) m_awready = 1'b1;
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; m_awready = 1'b0; m_wready = 1'b0;
      n_checks++;
      if (aw_hs != 1) begin
         n_errors++; $display("FAIL wr_aw_count: got %0d expected 1", aw_hs);
      end
      n_checks++;
      if (w_hs != 1) begin
         n_errors++; $display("FAIL wr_w_count: got %0d expected 1", w_hs);
      end
      step();
   endtask

   task automatic test_sel_during_read();
      int hs = 0;
      int acks = 0;
      logic bad = 1'b0;
      logic [14:0] ea;
      logic [31:0] er;
      q_addr.push_back(15'h0123);
      q_rdat.push_back(32'hCAFEF00D);
      s_arvalid = 1'b1; s_araddr = 15'h5123; m_arready = 1'b1; m_rvalid = 1'b0; s_rready = 1'b1;
      #2;
      n_checks++;
      if (m_arvalid !== 1'b0) begin
         n_errors++; $display("FAIL idle_no_forward: got m_arvalid %b expected 0", m_arvalid);
      end
      for (int c = 0; c < 10 && hs == 0; c++) begin
         step();
         #2;
         if (m_arvalid && m_arready) begin
            hs = 1;
            n_checks++;
            ea = (q_addr.size() != 0) ? q_addr.pop_front() : 15'h7FFF;
            if (m_araddr !== ea || s_arready !== 1'b1) begin
               n_errors++; $display("FAIL rd_araddr: got %h/%b expected %h/1", m_araddr, s_arready, ea);
            end
         end
      end
      step();
      s_arvalid = 1'b0; sel_req = 5'd3; sel_req_valid = 1'b1;
      step();
      sel_req_valid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         #2;
         if (user_prj_sel !== 5'd0 || sel_ack !== 1'b0) bad = 1'b1;
         step();
      end
      n_checks++;
      if (bad) begin
         n_errors++; $display("FAIL sel_held_during_read: got sel %h ack %b expected 00/0", user_prj_sel, sel_ack);
      end
      m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
      #2;
      n_checks++;
      er = (q_rdat.size() != 0) ? q_rdat.pop_front() : 32'hXXXXXXXX;
      if (s_rvalid !== 1'b1 || s_rdata !== er) begin
         n_errors++; $display("FAIL rd_rdata: got %b/%h expected 1/%h", s_rvalid, s_rdata, er);
      end
      step();
      m_rvalid = 1'b0;
      for (int c = 0; c < 6; c++) begin
         #2;
         if (sel_ack === 1'b1) acks++;
         step();
      end
      n_checks++;
      if (acks != 1) begin
         n_errors++; $display("FAIL sel_ack_count: got %0d expected 1", acks);
      end
      n_checks++;
      if (user_prj_sel !== 5'd3) begin
         n_errors++; $display("FAIL sel_applied: got %h expected 03", user_prj_sel);
      end
   endtask

   task automatic test_sel_overlap();
      int acks = 0;
      logic [4:0] es;
      // strobes 5 and 9 back to back: 9 overwrites 5; 12 lands in the SWITCH cycle
      q_sel.push_back(5'd9);
      q_sel.push_back(5'd12);
      sel_req = 5'd5; sel_req_valid = 1'b1;
      step();
      sel_req = 5'd9;
      step();
      sel_req = 5'd12;
      step();
      sel_req_valid = 1'b0;
      for (int c = 0; c < 8; c++) begin
         #2;
         if (sel_ack === 1'b1) begin
            acks++;
            n_checks++;
            es = (q_sel.size() != 0) ? q_sel.pop_front() : 5'h1F;
            if (user_prj_sel !== es) begin
               n_errors++; $display("FAIL sel_overlap_value: got %h expected %h", user_prj_sel, es);
            end
         end
         step();
      end
      n_checks++;
      if (acks != 2) begin
         n_errors++; $display("FAIL sel_overlap_acks: got %0d expected 2", acks);
      end
   endtask

   task automatic test_back_to_back();
      int ev = 0;
      logic eo;
      apply_reset();
      q_ord.push_back(1'b1); q_ord.push_back(1'b0);
      q_ord.push_back(1'b1); q_ord.push_back(1'b0);
      s_awvalid = 1'b1; s_awaddr = 15'h0010; s_wvalid = 1'b1; s_wdata = 32'h0BADF00D; s_wstrb = 4'hF;
      s_arvalid = 1'b1; s_araddr = 15'h0020; s_rready = 1'b1;
      m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1; m_rvalid = 1'b1; m_rdata = 32'h00000055;
      for (int c = 0; c < 40 && ev < 4; c++) begin
         #2;
         if ((m_awvalid && m_awready) || (m_arvalid && m_arready)) begin
            ev++;
            n_checks++;
            eo = (q_ord.size() != 0) ? q_ord.pop_front() : 1'bx;
            if (m_awvalid !== eo) begin
               n_errors++; $display("FAIL rr_order: event %0d got %s expected %s", ev,
                                    m_awvalid ? "W" : "R", eo ? "W" : "R");
            end
         end
         step();
      end
      s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
      step();
      m_rvalid = 1'b0;
      step();
      clear_inputs();
      n_checks++;
      if (ev != 4) begin
         n_errors++; $display("FAIL rr_count: got %0d expected 4", ev);
      end
   endtask

   task automatic test_reset_mid_write();
      int hs = 0;
      int aw_hs = 0;
      int w_hs = 0;
      logic [14:0] ea;
      logic [35:0] ew;
      sel_req = 5'd7; sel_req_valid = 1'b1;
      step();
      sel_req_valid = 1'b0;
      repeat (4) step();
      #2;
      n_checks++;
      if (user_prj_sel !== 5'd7) begin
         n_errors++; $display("FAIL pre_reset_sel: got %h expected 07", user_prj_sel);
      end
      step();
      q_addr.push_back(15'h0011);
      s_awvalid = 1'b1; s_awaddr = 15'h0011; s_wvalid = 1'b1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF;
      m_awready = 1'b1; m_wready = 1'b0;
      for (int c = 0; c < 10 && hs == 0; c++) begin
         #2;
         if (m_awvalid && m_awready) begin
            hs = 1;
            n_checks++;
            ea = (q_addr.size() != 0) ? q_addr.pop_front() : 15'h7FFF;
            if (m_awaddr !== ea) begin
               n_errors++; $display("FAIL abort_awaddr: got %h expected %h", m_awaddr, ea);
            end
         end
         step();
      end
      s_awvalid = 1'b0; m_awready = 1'b0;
      #2;
      m_wready = 1'b1;
      axi_reset_n = 1'b0;
      #1;
      n_checks++;
      if ({m_awvalid, m_wvalid, m_arvalid, s_awready, s_wready, s_arready, s_rvalid} !== 7'd0 ||
          s_rdata !== 32'd0) begin
         n_errors++; $display("FAIL mid_reset_outputs: got %b/%h expected 0000000/00000000",
                              {m_awvalid, m_wvalid, m_arvalid, s_awready, s_wready, s_arready, s_rvalid}, s_rdata);
      end
      n_checks++;
      if (user_prj_sel !== 5'd0 || sel_ack !== 1'b0) begin
         n_errors++; $display("FAIL mid_reset_sel: got %h/%b expected 00/0", user_prj_sel, sel_ack);
      end
      step();
      step();
      axi_reset_n = 1'b1; s_wvalid = 1'b0; m_wready = 1'b0;
      step();
      q_addr.push_back(15'h00CD);
      q_wdat.push_back({4'h3, 32'hA5A5A5A5});
      s_awvalid = 1'b1; s_awaddr = 15'h00CD; s_wvalid = 1'b1; s_wdata = 32'hA5A5A5A5; s_wstrb = 4'h3;
      m_awready = 1'b1; m_wready = 1'b1;
      for (int c = 0; c < 10 && !(aw_hs > 0 && w_hs > 0); c++) begin
         #2;
         if (m_awvalid && m_awready) begin
            aw_hs++;
            n_checks++;
            ea = (q_addr.size() != 0) ? q_addr.pop_front() : 15'h7FFF;
            if (m_awaddr !== ea) begin
               n_errors++; $display("FAIL post_reset_awaddr: got %h expected %h", m_awaddr, ea);
            end
         end
         if (m_wvalid && m_wready) begin
            w_hs++;
            n_checks++;
            ew = (q_wdat.size() != 0) ? q_wdat.pop_front() : 36'hFFFFFFFFF;
            if ({m_wstrb, m_wdata} !== ew) begin
               n_errors++; $display("FAIL post_reset_wdata: got %h expected %h", {m_wstrb, m_wdata}, ew);
            end
         end
         step();
      end
      clear_inputs();
      n_checks++;
      if (aw_hs != 1 || w_hs != 1) begin
         n_errors++; $display("FAIL post_reset_count: got aw %0d w %0d expected 1 1", aw_hs, w_hs);
      end
      step();
   endtask

   task automatic test_timeout();
      int hs = 0;
      logic [14:0] ea;
`ifdef AXIL_SEL_TIMEOUT_EN
      int waited = 0;
      logic seen = 1'b0;
`else
      logic bad = 1'b0;
      logic [31:0] er;
`endif
      q_addr.push_back(15'h0042);
      s_arvalid = 1'b1; s_araddr = 15'h0042; m_arready = 1'b1; m_rvalid = 1'b0; s_rready = 1'b0;
      for (int c = 0; c < 10 && hs == 0; c++) begin
         #2;
         if (m_arvalid && m_arready) begin
            hs = 1;
            n_checks++;
            ea = (q_addr.size() != 0) ? q_addr.pop_front() : 15'h7FFF;
            if (m_araddr !== ea) begin
               n_errors++; $display("FAIL tmo_araddr: got %h expected %h", m_araddr, ea);
            end
         end
         step();
      end
      s_arvalid = 1'b0; m_arready = 1'b0;
`ifdef AXIL_SEL_TIMEOUT_EN
      for (int c = 0; c < 40 && !seen; c++) begin
         #2;
         if (s_rvalid === 1'b1) begin
            seen = 1'b1;
         end else begin
            waited++;
            step();
         end
      end
      n_checks++;
      if (!seen || waited != 16) begin
         n_errors++; $display("FAIL tmo_latency: got %0d cycles (seen %b) expected 16", waited, seen);
      end
      n_checks++;
      if (s_rdata !== 32'hFFFFFFFF) begin
         n_errors++; $display("FAIL tmo_rdata: got %h expected ffffffff", s_rdata);
      end
      step();
      #2;
      n_checks++;
      if (s_rvalid !== 1'b1 || err_sticky !== 1'b1) begin
         n_errors++; $display("FAIL tmo_hold_err: got rvalid %b err %b expected 1 1", s_rvalid, err_sticky);
      end
      step();
      s_rready = 1'b1;
      step();
      s_rready = 1'b0; err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      #2;
      n_checks++;
      if (err_sticky !== 1'b0 || s_rvalid !== 1'b0) begin
         n_errors++; $display("FAIL tmo_err_clr: got err %b rvalid %b expected 0 0", err_sticky, s_rvalid);
      end
`else
      s_rready = 1'b1;
      for (int c = 0; c < 40; c++) begin
         #2;
         if (s_rvalid !== 1'b0 || err_sticky !== 1'b0) bad = 1'b1;
         err_clr = (c == 5);
         step();
      end
      err_clr = 1'b0;
      n_checks++;
      if (bad) begin
         n_errors++; $display("FAIL no_tmo_wait: got rvalid %b err %b expected 0 0", s_rvalid, err_sticky);
      end
      q_rdat.push_back(32'h13579BDF);
      m_rvalid = 1'b1; m_rdata = 32'h13579BDF;
      #2;
      n_checks++;
      er = (q_rdat.size() != 0) ? q_rdat.pop_front() : 32'hXXXXXXXX;
      if (s_rvalid !== 1'b1 || s_rdata !== er) begin
         n_errors++; $display("FAIL no_tmo_rdata: got %b/%h expected 1/%h", s_rvalid, s_rdata, er);
      end
      step();
      m_rvalid = 1'b0;
      #2;
      n_checks++;
      if (err_sticky !== 1'b0) begin
         n_errors++; $display("FAIL no_tmo_err: got %b expected 0", err_sticky);
      end
`endif
      clear_inputs();
      step();
   endtask

   initial begin
      test_reset();
      test_write();
      test_sel_during_read();
      test_sel_overlap();
      test_back_to_back();
      test_reset_mid_write();
      test_timeout();
      n_checks++;
      if (q_addr.size() != 0 || q_wdat.size() != 0 || q_rdat.size() != 0 || q_sel.size() != 0 || q_ord.size() != 0) begin
         n_errors++; $display("FAIL scoreboard_drain: got %0d entries left expected 0",
                              q_addr.size() + q_wdat.size() + q_rdat.size() + q_sel.size() + q_ord.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axil_sel_seq.md
AXIL_SEL_SEQ -- requirements
Module: axil_sel_seq

Interface
REQ-001 Parameter: pDATA_WIDTH, 32, AXI-Lite data width.
REQ-002 Parameter: pTIMEOUT, 255, max cycles waiting on downstream before self-completion (1..1023).
REQ-003 The block SHALL have one clock, axi_clk, and an asynchronous active-low reset, axi_reset_n.
REQ-004 Ports:
- axi_clk  in  1  clock.
- axi_reset_n  in  1  async active-low reset.
- s_awvalid/s_awready  in/out  1  upstream write address handshake.
- s_awaddr  in  15  write address.
- s_wvalid/s_wready  in/out  1  write data handshake.
- s_wdata  in  pDATA_WIDTH  write data.
- s_wstrb  in  4  write strobes.
- s_arvalid/s_arready  in/out  1  read address handshake.
- s_araddr  in  15  read address.
- s_rvalid/s_rready  out/in  1  read data handshake.
- s_rdata  out  pDATA_WIDTH  read data.
- m_* (awvalid, awready, awaddr, wvalid, wready, wdata, wstrb, arvalid, arready, araddr, rvalid, rready, rdata)  mirrored  -  downstream to the user-project mux.
- sel_req  in  5  requested user project select.
- sel_req_valid  in  1  one-cycle request strobe.
- user_prj_sel  out  5  applied select, to mux.
- sel_ack  out  1  one-cycle pulse when the select is applied.
- err_sticky  out  1  timeout occurred (requires AXIL_SEL_TIMEOUT_EN).
- err_clr  in  1  clears err_sticky.

Function
REQ-005 The FSM SHALL have states IDLE, WR, RD_A, RD_D and SWITCH; exactly one transaction is in flight at a time.
REQ-006 In IDLE, s_* SHALL NOT be forwarded; m_*valid SHALL be 0 and s_*ready SHALL be 0.
REQ-007 IDLE -> SWITCH when a select is pending; a pending select SHALL take priority over new transactions.
REQ-008 IDLE -> WR when s_awvalid and s_wvalid are both 1; IDLE -> RD_A when s_arvalid is 1.
REQ-009 When a write and a read are both eligible, the FSM SHALL alternate round-robin; after reset, the write wins first.
REQ-010 In WR, AW and W SHALL be passed through combinationally, each channel independently until its handshake completes.
- Each completed channel SHALL be masked (valid and ready 0).
- WR -> IDLE in the cycle after both handshakes have completed.
REQ-011 In RD_A, AR SHALL be passed through; RD_A -> RD_D on the m_arvalid&&m_arready handshake.
REQ-012 In RD_D, R SHALL be passed through; RD_D -> IDLE on the s_rvalid&&s_rready handshake.
REQ-013 Address and data SHALL reach m_* unmodified; m_awaddr and m_araddr SHALL carry bits [11:0] zero-extended, with [14:12] ignored.
REQ-014 A sel_req_valid strobe SHALL latch sel_req into the pending register.
- A later strobe before application overwrites the pending value (last wins).
REQ-015 In SWITCH (one cycle), user_prj_sel SHALL be loaded from the pending register, sel_ack SHALL pulse, and the FSM SHALL return to IDLE.
REQ-016 A strobe arriving in the same cycle as SWITCH SHALL remain pending and be applied in a later SWITCH.
REQ-017 user_prj_sel SHALL NOT change in any state other than SWITCH.

Reset
REQ-018 On axi_reset_n low, reset SHALL take effect asynchronously and force: state IDLE, user_prj_sel 5'b00000, pending cleared, sel_ack 0, err_sticky 0, timeout counter 0, round-robin pointer set to write.
REQ-019 During reset, all m_*valid and s_*ready/s_rvalid outputs SHALL be 0 and s_rdata SHALL be 0.
REQ-020 A reset asserted mid-transaction SHALL abandon the transaction without completing any handshake.

Configuration
REQ-021 Macro AXIL_SEL_TIMEOUT_EN, when defined, SHALL enable a 10-bit counter that clears on entry to WR, RD_A or RD_D and increments each cycle in those states.
- When the count reaches pTIMEOUT in WR or RD_A, the block SHALL self-complete: for one cycle it asserts the outstanding s_*ready, drives m_*valid 0, and the FSM goes to IDLE (from RD_A via RD_D).
- When the count reaches pTIMEOUT in RD_D, the block SHALL drive s_rvalid=1 with s_rdata all ones until s_rready, then go to IDLE.
- Each timeout SHALL set err_sticky; err_clr SHALL clear it, and a set on the same cycle wins.
REQ-022 Without AXIL_SEL_TIMEOUT_EN, there SHALL be no counter, states SHALL wait indefinitely, err_sticky SHALL be tied to 0 and err_clr SHALL be ignored.

Verification
REQ-023 Write 0x0AB/0x12345678 with m_awready delayed 3 cycles and m_wready immediate -> each channel handshakes exactly once, m_awaddr 0x0AB, FSM back in IDLE.
REQ-024 sel_req=3 strobe while RD_D is waiting on m_rvalid -> user_prj_sel stays 0 until the read completes, then becomes 3 with one sel_ack pulse.
REQ-025 s_awvalid+s_wvalid and s_arvalid held together for 4 transactions -> order is W,R,W,R.
REQ-026 With AXIL_SEL_TIMEOUT_EN and pTIMEOUT=16, a read with m_rvalid never asserted -> s_rdata 0xFFFFFFFF at cycle 16 of RD_D and err_sticky=1; err_clr then clears it.
REQ-027 axi_reset_n pulsed low during WR after the AW handshake only -> all outputs 0 immediately, user_prj_sel 0, and the next write is forwarded in full.
